// File: rtl/fft_bfly_scheduler.sv
// Butterfly sequencer for an in-place radix-2 DIT FFT: walks every stage and
// butterfly, issues read pairs plus twiddle indices, and replays them as write-backs.
module fft_bfly_scheduler #(
    parameter int LOG2N    = 8,
    parameter int BFLY_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam int CW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [CW-1:0]    LAST_CNT   = CW'(BFLY_LAT - 1);
    localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic             vld;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } slot_t;

    // Upper-leg address: insert a zero bit at position s of butterfly index k.
    function automatic logic [LOG2N-1:0] f_addr_a(input logic [KW-1:0] k,
                                                  input logic [SW-1:0] s);
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] mask;
        kk   = {1'b0, k};
        mask = (ONE << s) - ONE;
        return ((kk & ~mask) << 1) | (kk & mask);
    endfunction

    function automatic logic [KW-1:0] f_tw(input logic [KW-1:0] k,
                                           input logic [SW-1:0] s);
        logic [KW-1:0] mask;
        mask = (KW'(1) << s) - KW'(1);
        return (k & mask) << (SW'(KW) - s);
    endfunction

    state_t           r_state;
    state_t           w_nxt_state;
    logic [SW-1:0]    r_stage;
    logic [SW-1:0]    w_nxt_stage;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    w_nxt_k;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_nxt_cnt;
    logic             r_vld;
    logic             w_nxt_vld;
    logic             w_stall;

    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic             r_wr_en;
    logic [LOG2N-1:0] r_rd_a;
    logic [LOG2N-1:0] r_rd_b;
    logic [KW-1:0]    r_tw;

    slot_t            r_dl    [BFLY_LAT];
    slot_t            w_chain [BFLY_LAT+1];

    // r_vld marks the slot currently on the read port as issued; it stays set
    // through a hold so the stalled butterfly still enters the delay line once.
    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned and no latch is inferred.
        w_nxt_state = r_state;
        w_nxt_stage = r_stage;
        w_nxt_k     = r_k;
        w_nxt_cnt   = r_cnt;
        w_nxt_vld   = r_vld;
        w_stall     = hold && ((r_state == S_ISSUE) || (r_state == S_DRAIN));

        unique case (r_state)
            S_IDLE, S_DONE: begin
                w_nxt_state = S_IDLE;
                w_nxt_vld   = 1'b0;
                if (start) begin
                    w_nxt_state = S_ISSUE;
                    w_nxt_stage = '0;
                    w_nxt_k     = '0;
                    w_nxt_vld   = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!w_stall) begin
                    if (r_k == '1) begin
                        w_nxt_state = S_DRAIN;
                        w_nxt_cnt   = '0;
                        w_nxt_vld   = 1'b0;
                    end else begin
                        w_nxt_k = r_k + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!w_stall) begin
                    if (r_cnt == LAST_CNT) begin
                        if (r_stage == LAST_STAGE) begin
                            w_nxt_state = S_DONE;
                        end else begin
                            w_nxt_state = S_ISSUE;
                            w_nxt_stage = r_stage + SW'(1);
                            w_nxt_k     = '0;
                            w_nxt_vld   = 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_vld   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_chain[0] = {r_vld, r_rd_a, r_rd_b};
        for (int i = 0; i < BFLY_LAT; i++) begin
            w_chain[i+1] = r_dl[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register here sample pre-edge values regardless of statement order.
            r_state <= w_nxt_state;
            r_stage <= w_nxt_stage;
            r_k     <= w_nxt_k;
            r_cnt   <= w_nxt_cnt;
            r_vld   <= w_nxt_vld;
            r_busy  <= (w_nxt_state == S_ISSUE) || (w_nxt_state == S_DRAIN);
            r_done  <= (w_nxt_state == S_DONE);
            r_rd_en <= w_nxt_vld && !w_stall;
            if (w_nxt_vld && !w_stall) begin
                r_rd_a <= f_addr_a(w_nxt_k, w_nxt_stage);
                r_rd_b <= f_addr_a(w_nxt_k, w_nxt_stage) | (ONE << w_nxt_stage);
                r_tw   <= f_tw(w_nxt_k, w_nxt_stage);
            end
        end
    end

    // The last delay-line slot doubles as the write-address register; wr_en is
    // kept separately so a hold can blank it without losing the pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this delay line is a handful of flops, not a RAM, so it is reset to drop writes still in flight.
            for (int i = 0; i < BFLY_LAT; i++) begin
                r_dl[i] <= '0;
            end
            r_wr_en <= 1'b0;
        end else begin
            if (!w_stall) begin
                for (int i = 0; i < BFLY_LAT; i++) begin
                    r_dl[i] <= w_chain[i];
                end
            end
            r_wr_en <= !w_stall && w_chain[BFLY_LAT-1].vld;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign stage     = r_stage;
    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign tw_addr   = r_tw;
    assign wr_en     = r_wr_en;
    assign wr_addr_a = r_dl[BFLY_LAT-1].a;
    assign wr_addr_b = r_dl[BFLY_LAT-1].b;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed bench for fft_bfly_scheduler with an 8-point FFT and a 2-cycle datapath:
// nominal pass, hold stall, ignored starts, back-to-back passes and mid-run reset.
module tb_fft_bfly_scheduler;

    localparam int LOG2N    = 3;
    localparam int BFLY_LAT = 2;
    localparam int PASS_LEN = 19;

    logic                     clk     = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     start   = 1'b0;
    logic                     hold    = 1'b0;
    logic                     busy;
    logic                     done;
    logic [$clog2(LOG2N)-1:0] stage;
    logic                     rd_en;
    logic [LOG2N-1:0]         rd_addr_a;
    logic [LOG2N-1:0]         rd_addr_b;
    logic [LOG2N-2:0]         tw_addr;
    logic                     wr_en;
    logic [LOG2N-1:0]         wr_addr_a;
    logic [LOG2N-1:0]         wr_addr_b;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-derived butterfly order for N=8: stage 0, stage 1, stage 2.
    int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    fft_bfly_scheduler #(
        .LOG2N   (LOG2N),
        .BFLY_LAT(BFLY_LAT)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_en    (rd_en),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .tw_addr  (tw_addr),
        .wr_en    (wr_en),
        .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Events at or after the first hold cycle slip by the hold length.
    function automatic int shift_ev(input int nominal, input int hlo, input int hlen);
        return (hlen > 0 && nominal >= hlo) ? nominal + hlen : nominal;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " busy"},  busy,  0);
        check({tag, " done"},  done,  0);
        check({tag, " rd_en"}, rd_en, 0);
        check({tag, " wr_en"}, wr_en, 0);
    endtask

    task automatic check_cycle(input int c, input int passes, input int hlo, input int hhi);
        int  hlen;
        int  rd_i;
        int  wr_i;
        int  base;
        int  nom;
        bit  e_busy;
        bit  e_done;
        hlen   = (hlo > 0) ? hhi - hlo + 1 : 0;
        rd_i   = -1;
        wr_i   = -1;
        e_busy = 1'b0;
        e_done = 1'b0;
        for (int p = 0; p < passes; p++) begin
            base = PASS_LEN * p;
            for (int i = 0; i < 12; i++) begin
                nom = base + 1 + 6 * (i / 4) + (i % 4);
                if (shift_ev(nom, hlo, hlen) == c)     rd_i = i;
                if (shift_ev(nom + 2, hlo, hlen) == c) wr_i = i;
            end
            if (shift_ev(base + PASS_LEN, hlo, hlen) == c) e_done = 1'b1;
            if (c >= base + 1 && c <= shift_ev(base + 18, hlo, hlen)) e_busy = 1'b1;
        end
        check($sformatf("c%0d busy", c),  busy,  e_busy);
        check($sformatf("c%0d done", c),  done,  e_done);
        check($sformatf("c%0d rd_en", c), rd_en, (rd_i >= 0));
        check($sformatf("c%0d wr_en", c), wr_en, (wr_i >= 0));
        if (rd_i >= 0) begin
            check($sformatf("c%0d rd_addr_a", c), rd_addr_a, exp_a[rd_i]);
            check($sformatf("c%0d rd_addr_b", c), rd_addr_b, exp_b[rd_i]);
            check($sformatf("c%0d tw_addr", c),   tw_addr,   exp_tw[rd_i]);
            check($sformatf("c%0d stage", c),     stage,     rd_i / 4);
        end
        if (wr_i >= 0) begin
            check($sformatf("c%0d wr_addr_a", c), wr_addr_a, exp_a[wr_i]);
            check($sformatf("c%0d wr_addr_b", c), wr_addr_b, exp_b[wr_i]);
        end
    endtask

    // Called at a negedge with the DUT idle. Inputs for cycle c+1 are set at the
    // negedge of cycle c, so they are sampled by the edge that opens cycle c+1.
    task automatic run_scenario(input string name, input int hlo, input int hhi,
                                input int st_a, input int st_b, input int passes);
        int last;
        last  = PASS_LEN * passes + ((hlo > 0) ? hhi - hlo + 1 : 0);
        start = 1'b1;
        hold  = (hlo == 1);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(c, passes, hlo, hhi);
            start = (passes > 1 && c + 1 <= PASS_LEN * passes) || (c + 1 == st_a) || (c + 1 == st_b);
            hold  = (hlo > 0 && c + 1 >= hlo && c + 1 <= hhi);
        end
        start = 1'b0;
        hold  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle({name, " after"});
    endtask

    initial begin
        int n_run;

        repeat (2) @(negedge clk);
        check_idle("por");
        check("por rd_addr_a", rd_addr_a, 0);
        check("por wr_addr_b", wr_addr_b, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        run_scenario("nominal", 0, 0, 0, 0, 1);
        run_scenario("hold",    3, 5, 0, 0, 1);
        run_scenario("ignore",  0, 0, 4, 10, 1);
        run_scenario("b2b",     0, 0, 0, 0, 2);

        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_run = $urandom_range(3, 15);
        for (int i = 0; i < n_run; i++) begin
            hold = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        hold = 1'b0;
        check("midrun busy", busy, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_idle("rst");
        check("rst stage",     stage,     0);
        check("rst rd_addr_a", rd_addr_a, 0);
        check("rst rd_addr_b", rd_addr_b, 0);
        check("rst tw_addr",   tw_addr,   0);
        check("rst wr_addr_a", wr_addr_a, 0);
        check("rst wr_addr_b", wr_addr_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("post_rst%0d", i));
        end
        run_scenario("restart", 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_bfly_scheduler.md
Name: fft_bfly_scheduler

Overview:
Sequencer for the in-place radix-2 DIT FFT engine of the audio visualizer.
- Walks all LOG2N stages and all N/2 butterflies per stage.
- Issues sample-RAM read pairs and twiddle-ROM indices to the complex adder/subtractor/multiplier butterfly datapath.
- Issues matching write-back addresses after the datapath latency.
- Sits between the frame-capture logic, which pulses start, and the magnitude/display stage, which consumes done.

Parameters:
LOG2N, 8, log2 of FFT length; N = 2^LOG2N.
BFLY_LAT, 2, cycles from rd_en to butterfly result valid at the RAM write port; must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  request one full FFT pass; sampled in IDLE or DONE only.
hold  in  1  stall; freezes issue and write pipeline (datapath stalls on the same signal).
busy  out  1  high from the cycle after start is accepted through the last drain cycle.
done  out  1  one-cycle pulse after the final write.
stage  out  $clog2(LOG2N)  current stage index.
rd_en  out  1  read pair valid.
rd_addr_a  out  LOG2N  upper-leg read address.
rd_addr_b  out  LOG2N  lower-leg read address.
tw_addr  out  LOG2N-1  twiddle ROM index.
wr_en  out  1  write-back pair valid.
wr_addr_a  out  LOG2N  upper-leg write address.
wr_addr_b  out  LOG2N  lower-leg write address.

Behaviour:
- All outputs are registered. On reset_n low, all outputs go to 0 immediately, the state goes to IDLE, and the write delay line is cleared; pending writes are dropped.
- States:
  - IDLE: on start, go to ISSUE with stage=0, k=0.
  - ISSUE: one butterfly per non-hold cycle. After k = N/2-1 is issued, go to DRAIN.
  - DRAIN: lasts BFLY_LAT non-hold cycles with rd_en=0. Then, if stage < LOG2N-1, increment stage, set k=0, go to ISSUE; otherwise go to DONE.
  - DONE: done=1, busy=0 for one cycle. A start in this cycle is accepted (back-to-back frames); otherwise go to IDLE.
- start is ignored while busy.
- Address generation for stage s and butterfly k:
  - span = 2^s, pos = k & (span-1), grp = k >> s.
  - rd_addr_a = grp*2*span + pos.
  - rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (LOG2N-1-s).
  - All arithmetic is unsigned and never exceeds N-1.
- Write path:
  - wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly BFLY_LAT non-hold cycles, via a shift register.
  - wr_en=0 otherwise.
- Hazard rule: stage s+1 issues no read before the last write of stage s has been presented. DRAIN guarantees this.
- hold=1:
  - rd_en=0 and wr_en=0.
  - k, stage, state, address outputs and delay-line contents are frozen.
  - Operation resumes exactly where it left off.
  - A hold in DONE has no effect; the done pulse is not extended.
- Cycle count without hold: done asserts N/2*LOG2N + LOG2N*BFLY_LAT + 1 cycles after the start-sampling edge.

Test Plan:
1. Reset: drive reset_n=0 mid-run with a random state -> all outputs 0 in the same cycle; after release, IDLE with no rd_en or wr_en until start.
2. Stage 0 (LOG2N=3, BFLY_LAT=2): pulse start at edge E0.
   - Cycles 1-4: rd pairs (0,1),(2,3),(4,5),(6,7), all tw=0.
   - Cycles 3-6: wr pairs identical to the rd pairs.
   - Cycles 5-6: rd_en=0.
3. Stages 1/2 (same config):
   - Stage 1 issue, cycles 7-10: (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2.
   - Stage 2 issue, cycles 13-16: (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3.
   - done=1 in cycle 19 only; busy high in cycles 1-18.
4. Hold: hold=1 for cycles 3-5 of stage 0 ->
   - rd_en and wr_en low in cycles 3-5.
   - Issue resumes with (4,5) in cycle 6.
   - Every later event shifts by 3; done in cycle 22.
5. start asserted in cycles 4 and 10 -> ignored; pass identical to scenario 3.
6. Back-to-back: start held high continuously -> second pass begins in the cycle after the done cycle with rd (0,1); done pulses in cycles 19 and 38.
